// File: rtl/vip_osd_text_loader.sv
// Renders a TEXT_ROWS x TEXT_COLS character buffer into the vip_osd 1-bpp bitmap RAM.
// Optional build macro OSD_TEXT_INVERT_EN: txt_wdata[7] selects inverse video per character.
module vip_osd_text_loader #(
  parameter int OSD_RAM_ADDR_BITS = 9,
  parameter int OSD_RAM_DATA_BITS = 32,
  parameter int TEXT_COLS         = 16,
  parameter int TEXT_ROWS         = 2,
  parameter int FONT_H            = 16,
  localparam int WPR              = TEXT_COLS / 4,
  localparam int NW               = TEXT_ROWS * FONT_H * WPR,
  localparam int NCH              = TEXT_COLS * TEXT_ROWS,
  localparam int TAB              = $clog2(NCH),
  localparam int GRB              = $clog2(FONT_H),
  localparam int FAB              = 7 + GRB
) (
  input  logic                         osd_ram_clk,
  input  logic                         rst,
  input  logic                         txt_wen,
  input  logic [TAB-1:0]               txt_addr,
  input  logic [7:0]                   txt_wdata,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [FAB-1:0]               font_addr,
  input  logic [7:0]                   font_data,
  output logic                         osd_ram_wen,
  output logic [OSD_RAM_ADDR_BITS-1:0] osd_ram_addr,
  output logic [OSD_RAM_DATA_BITS-1:0] osd_ram_wdata
);

  localparam int CB = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int LB = (TEXT_ROWS > 1) ? $clog2(TEXT_ROWS) : 1;
`ifdef OSD_TEXT_INVERT_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t                       state;
  logic [2:0]                   ph;
  logic [OSD_RAM_ADDR_BITS-1:0] wrd;
  logic [CB-1:0]                col;
  logic [GRB-1:0]               grow;
  logic [LB-1:0]                line;
  logic [23:0]                  acc;

  logic [CB-1:0]                nxt_col;
  logic [GRB-1:0]               nxt_row;
  logic [LB-1:0]                nxt_line;
  logic [CB-1:0]                f_col;
  logic [GRB-1:0]               f_row;
  logic [LB-1:0]                f_line;
  logic [1:0]                   f_k;
  logic [TAB-1:0]               fetch_idx;
  logic [CW-1:0]                fetch_ch;
  logic [FAB-1:0]               fetch_addr;
  logic [7:0]                   glyph;
  logic                         last_word;

  logic [CW-1:0]                text_buf [NCH];

  function automatic logic [TAB-1:0] char_idx(input logic [LB-1:0] ln,
                                               input logic [CB-1:0] cw,
                                               input logic [1:0]    k);
    int i;
    i = int'(ln) * TEXT_COLS + 4 * int'(cw) + int'(k);
    return TAB'(i);
  endfunction

  // NOTE: the buffer is built from flops rather than a RAM macro so it can be
  // cleared to spaces by reset; a RAM block would keep stale text across reset.
  always_ff @(posedge osd_ram_clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) text_buf[i] <= CW'(8'h20);
    end else if (txt_wen && (int'(txt_addr) < NCH)) begin
      text_buf[txt_addr] <= txt_wdata[CW-1:0];
    end
  end

  // Position of the word after the current one (line, glyph row, word column).
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt_col  = col;
    nxt_row  = grow;
    nxt_line = line;
    if (col == CB'(WPR - 1)) begin
      nxt_col = '0;
      if (grow == GRB'(FONT_H - 1)) begin
        nxt_row  = '0;
        nxt_line = line + 1'b1;
      end else begin
        nxt_row = grow + 1'b1;
      end
    end else begin
      nxt_col = col + 1'b1;
    end
  end

  // Which character is looked up this cycle: the first glyph of the next word at
  // the period boundary (or at start), otherwise glyph ph of the current word.
  always_comb begin
    f_line = '0;
    f_col  = '0;
    f_row  = '0;
    f_k    = '0;
    if (state == S_FETCH) begin
      if (ph == 3'd0) begin
        f_line = nxt_line;
        f_col  = nxt_col;
        f_row  = nxt_row;
      end else begin
        f_line = line;
        f_col  = col;
        f_row  = grow;
        f_k    = ph[1:0];
      end
    end
  end

  assign fetch_idx  = char_idx(f_line, f_col, f_k);
  assign fetch_ch   = text_buf[fetch_idx];
  assign fetch_addr = {fetch_ch[6:0], f_row};
  assign last_word  = (wrd == OSD_RAM_ADDR_BITS'(NW - 1));

`ifdef OSD_TEXT_INVERT_EN
  // The invert flag travels two cycles behind its lookup to meet the ROM data.
  logic inv_p1, inv_p2;

  always_ff @(posedge osd_ram_clk) begin
    if (rst) begin
      inv_p1 <= 1'b0;
      inv_p2 <= 1'b0;
    end else begin
      inv_p1 <= fetch_ch[7];
      inv_p2 <= inv_p1;
    end
  end

  assign glyph = font_data ^ {8{inv_p2}};
`else
  logic unused_invert;
  assign unused_invert = txt_wdata[7];
  assign glyph         = font_data;
`endif

  // NOTE: all state and outputs are registered with non-blocking assignments so
  // every flop in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge osd_ram_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      osd_ram_wen   <= 1'b0;
      osd_ram_addr  <= '0;
      osd_ram_wdata <= '0;
      font_addr     <= '0;
      ph            <= '0;
      wrd           <= '0;
      col           <= '0;
      grow          <= '0;
      line          <= '0;
      acc           <= '0;
    end else begin
      done        <= 1'b0;
      osd_ram_wen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            font_addr <= fetch_addr;
            ph        <= 3'd1;
            wrd       <= '0;
            col       <= '0;
            grow      <= '0;
            line      <= '0;
          end
        end
        S_FETCH: begin
          case (ph)
            3'd1: begin
              font_addr <= fetch_addr;
              ph        <= 3'd2;
            end
            3'd2, 3'd3: begin
              font_addr <= fetch_addr;
              acc       <= {acc[15:0], glyph};
              ph        <= ph + 3'd1;
            end
            3'd4: begin
              acc <= {acc[15:0], glyph};
              ph  <= 3'd0;
            end
            default: begin
              // Fourth glyph byte completes the word; it is written as the next period opens.
              osd_ram_wen   <= 1'b1;
              osd_ram_addr  <= wrd;
              osd_ram_wdata <= OSD_RAM_DATA_BITS'({acc, glyph});
              if (last_word) begin
                state <= S_DONE;
              end else begin
                font_addr <= fetch_addr;
                wrd       <= wrd + 1'b1;
                col       <= nxt_col;
                grow      <= nxt_row;
                line      <= nxt_line;
                ph        <= 3'd1;
              end
            end
          endcase
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_osd_text_loader.sv
// Randomized self-checking bench for vip_osd_text_loader with a word-level reference model.
// Honours OSD_TEXT_INVERT_EN the same way the design build does.
module tb_vip_osd_text_loader;

  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 2;
  localparam int FONT_H    = 16;
  localparam int WPR       = TEXT_COLS / 4;
  localparam int NW        = TEXT_ROWS * FONT_H * WPR;
  localparam int NCH       = TEXT_COLS * TEXT_ROWS;
  localparam int TAB       = $clog2(NCH);
  localparam int GRB       = $clog2(FONT_H);
  localparam int FAB       = 7 + GRB;
  localparam int AB        = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           txt_wen = 1'b0;
  logic [TAB-1:0] txt_addr = '0;
  logic [7:0]     txt_wdata = '0;
  logic           start = 1'b0;
  logic           busy, done, osd_ram_wen;
  logic [FAB-1:0] font_addr;
  logic [7:0]     font_data;
  logic [AB-1:0]  osd_ram_addr;
  logic [31:0]    osd_ram_wdata;

  vip_osd_text_loader dut (
    .osd_ram_clk  (clk),
    .rst          (rst),
    .txt_wen      (txt_wen),
    .txt_addr     (txt_addr),
    .txt_wdata    (txt_wdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .font_addr    (font_addr),
    .font_data    (font_data),
    .osd_ram_wen  (osd_ram_wen),
    .osd_ram_addr (osd_ram_addr),
    .osd_ram_wdata(osd_ram_wdata)
  );

  always #5 clk = ~clk;

  // Font ROM: {code[3:0], glyph_row[3:0]}, one cycle of latency.
  always @(posedge clk) font_data <= {font_addr[GRB+3:GRB], font_addr[3:0]};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A value registered at edge n is what the timing rules call cycle n+1.
  logic [AB-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];
  int            wq_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            high_wr  = 0;

  always @(posedge clk) begin
    #1;
    if (osd_ram_wen) begin
      wq_addr.push_back(osd_ram_addr);
      wq_data.push_back(osd_ram_wdata);
      wq_cyc.push_back(cyc + 1);
      if (int'(osd_ram_addr) >= NW) high_wr++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference text buffer and word model.
  logic [7:0] ref_txt [NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) ref_txt[i] = 8'h20;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    int r, c, ln, gr;
    logic [7:0]  ch, b;
    logic [31:0] v;
    r  = w / WPR;
    c  = w % WPR;
    ln = r / FONT_H;
    gr = r % FONT_H;
    v  = '0;
    for (int k = 0; k < 4; k++) begin
      ch = ref_txt[ln * TEXT_COLS + 4 * c + k];
      b  = {ch[3:0], 4'(gr)};
`ifdef OSD_TEXT_INVERT_EN
      if (ch[7]) b = ~b;
`endif
      v = {v[23:0], b};
    end
    return v;
  endfunction

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt = 0;
    high_wr  = 0;
  endtask

  task automatic tb_write(input int idx, input logic [7:0] val);
    @(negedge clk);
    txt_wen   = 1'b1;
    txt_addr  = TAB'(idx);
    txt_wdata = val;
    @(negedge clk);
    txt_wen = 1'b0;
`ifdef OSD_TEXT_INVERT_EN
    ref_txt[idx] = val;
`else
    ref_txt[idx] = {1'b0, val[6:0]};
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Pulse start, optionally re-pulse it extra_at cycles later, wait for done.
  task automatic run_render(input string tag, input int extra_at, output int ts);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    ts = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    for (int i = 2; i < 5 * NW + 50 && done_cnt == 0; i++) begin
      start = (i == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_time"}, done_cyc, ts + 5 * NW + 2);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic verify_render(input string tag, input int ts);
    check({tag, "_nwrites"}, wq_addr.size(), NW);
    check({tag, "_high_wr"}, high_wr, 0);
    if (wq_addr.size() == NW) begin
      for (int i = 0; i < NW; i++) begin
        check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
        check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_word(i));
        check($sformatf("%s_time%0d", tag, i), wq_cyc[i], ts + 6 + 5 * i);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int ts;
    logic [31:0] inv_word0;
    model_reset();

    // Reset state and idle behaviour.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wen", osd_ram_wen, 0);
    check("rst_addr", osd_ram_addr, 0);
    check("rst_wdata", osd_ram_wdata, 0);
    check("rst_font_addr", font_addr, 0);
    rst = 1'b0;
    clear_mon();
    repeat (1000) @(negedge clk);
    check("idle_nwrites", wq_addr.size(), 0);
    check("idle_done", done_cnt, 0);

    // Single 'A' at the top-left corner.
    tb_write(0, 8'h41);
    run_render("a", -1, ts);
    verify_render("a", ts);
    if (wq_data.size() == NW) begin
      check("a_word0", wq_data[0], 32'h10000000);
      check("a_word1", wq_data[1], 32'h00000000);
      check("a_word4", wq_data[4], 32'h11010101);
    end

    // 'B' on line 1, fresh buffer; a second start while busy must be ignored.
    do_reset(1);
    tb_write(16, 8'h42);
    run_render("b", 50, ts);
    verify_render("b", ts);
    if (wq_data.size() == NW) begin
      check("b_word64", wq_data[64], 32'h20000000);
      check("b_word0", wq_data[0], 32'h00000000);
    end
    run_render("b2", -1, ts);
    verify_render("b2", ts);

    // Random text, including invert flags.
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < 24; j++) tb_write($urandom_range(NCH - 1), 8'($urandom_range(255)));
      run_render($sformatf("rnd%0d", pass), -1, ts);
      verify_render($sformatf("rnd%0d", pass), ts);
    end

    // Reset in the tenth write period.
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && wq_addr.size() < 9; i++) @(negedge clk);
    check("rr_reached9", wq_addr.size(), 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rr_wen", osd_ram_wen, 0);
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    repeat (5 * NW + 20) @(negedge clk);
    check("rr_nwrites", wq_addr.size(), 9);
    check("rr_done_cnt", done_cnt, 0);

    // Start coinciding with reset.
    clear_mon();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rs_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("rs_nwrites", wq_addr.size(), 0);

    // Inverse-video character.
    tb_write(0, 8'hC1);
    run_render("inv", -1, ts);
    verify_render("inv", ts);
`ifdef OSD_TEXT_INVERT_EN
    inv_word0 = 32'hEF000000;
`else
    inv_word0 = 32'h10000000;
`endif
    if (wq_data.size() == NW) check("inv_word0", wq_data[0], inv_word0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
